// File: rtl/sha256_pkg.sv
// SHA-256 constants, shared types and round helper functions for the block engine.
package sha256_pkg;

  typedef logic [31:0] word_t;
  // Element 0 (a / H0) sits in the MSBs, so a state_t maps directly onto a digest bus.
  typedef word_t [0:7] state_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } fsm_t;

  localparam state_t IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam word_t K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic word_t rotr(input word_t x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic word_t ch(input word_t x, input word_t y, input word_t z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic word_t maj(input word_t x, input word_t y, input word_t z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  function automatic word_t Sigma0(input word_t x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic word_t Sigma1(input word_t x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic word_t sigma0(input word_t x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic word_t sigma1(input word_t x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // Feed-forward: word-wise modulo-2^32 sum of chaining value and working variables.
  function automatic state_t add_state(input state_t x, input state_t y);
    state_t r;
    for (int unsigned i = 0; i < 8; i++) r[i] = x[i] + y[i];
    return r;
  endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 compression round: (a..h, W[t], K[t]) -> (a'..h').
module sha256_round
  import sha256_pkg::*;
(
  input  state_t s_in,
  input  word_t  w,
  input  word_t  k,
  output state_t s_out
);

  word_t t1;
  word_t t2;

  always_comb begin
    t1    = s_in[7] + Sigma1(s_in[4]) + ch(s_in[4], s_in[5], s_in[6]) + k + w;
    t2    = Sigma0(s_in[0]) + maj(s_in[0], s_in[1], s_in[2]);
    s_out = {t1 + t2, s_in[0], s_in[1], s_in[2], s_in[3] + t1, s_in[4], s_in[5], s_in[6]};
  end

endmodule

// File: rtl/sha256_block_engine.sv
// Iterative SHA-256 block compression, UNROLL rounds per clock, valid/ready on both sides.
module sha256_block_engine
  import sha256_pkg::*;
#(
  parameter int UNROLL  = 1,
  parameter bit OUT_REG = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] in_block,
  input  logic [255:0] in_chain,
  input  logic         in_use_iv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] out_digest,
  output logic         busy
);

  if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 8)) begin : g_bad_unroll
    $error("sha256_block_engine: UNROLL must be 1, 2, 4 or 8");
  end

  fsm_t       state;
  logic [6:0] cnt;
  state_t     h;
  state_t     v;
  word_t      w_buf  [16];
  word_t      w_next [16];
  word_t      w_r    [UNROLL];
  word_t      k_r    [UNROLL];
  state_t     chain_s [UNROLL+1];
  logic       accept;
  logic       last;

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign busy      = (state != ST_IDLE);
  assign accept    = in_valid && in_ready;
  assign last      = ((cnt + 7'(UNROLL)) == 7'd64);

  // Expand the schedule in place: slot t mod 16 still holds W[t-16] until overwritten,
  // and later rounds in the same cycle see the freshly written words.
  always_comb begin
    w_next = w_buf;
    for (int unsigned j = 0; j < UNROLL; j++) begin
      if ((cnt + 7'(j)) >= 7'd16) begin
        w_next[4'(cnt[3:0] + 4'(j))] = sigma1(w_next[4'(cnt[3:0] + 4'(j) - 4'd2)])
                                     + w_next[4'(cnt[3:0] + 4'(j) - 4'd7)]
                                     + sigma0(w_next[4'(cnt[3:0] + 4'(j) - 4'd15)])
                                     + w_next[4'(cnt[3:0] + 4'(j))];
      end
      w_r[j] = w_next[4'(cnt[3:0] + 4'(j))];
      k_r[j] = K[6'(cnt[5:0] + 6'(j))];
    end
  end

  assign chain_s[0] = v;

  for (genvar g = 0; g < UNROLL; g++) begin : g_round
    sha256_round u_round (
      .s_in  (chain_s[g]),
      .w     (w_r[g]),
      .k     (k_r[g]),
      .s_out (chain_s[g+1])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      h     <= '0;
      v     <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            state <= ST_RUN;
            cnt   <= '0;
            h     <= in_use_iv ? IV : state_t'(in_chain);
            v     <= in_use_iv ? IV : state_t'(in_chain);
          end
        end
        ST_RUN: begin
          v   <= chain_s[UNROLL];
          cnt <= cnt + 7'(UNROLL);
          if (last) state <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int unsigned i = 0; i < 16; i++) w_buf[i] <= in_block[511 - 32*i -: 32];
    end else if (state == ST_RUN) begin
      w_buf <= w_next;
    end
  end

  if (OUT_REG) begin : g_out_reg
    state_t digest_q;
    always_ff @(posedge clk) begin
      if (rst)                       digest_q <= '0;
      else if (state == ST_RUN && last) digest_q <= add_state(h, chain_s[UNROLL]);
    end
    assign out_digest = digest_q;
  end else begin : g_out_comb
    assign out_digest = add_state(h, v);
  end

endmodule

// File: tb/tb_sha256_block_engine.sv
// Self-checking bench: four engine configurations against known vectors and a behavioural SHA-256 model.
module tb_sha256_block_engine;

  localparam logic [31:0] TB_K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam logic [255:0] TB_IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [511:0] ABC_BLK   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] EMPTY_BLK = {32'h80000000, 480'h0};
  localparam logic [511:0] TWO_BLK1  = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f, 32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000
  };
  localparam logic [511:0] TWO_BLK2  = {480'h0, 32'h000001c0};

  localparam logic [255:0] ABC_DIG   = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] EMPTY_DIG = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
  localparam logic [255:0] TWO_DIG   = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

  localparam int UNROLL_OF [4] = '{1, 2, 4, 8};

  logic         clk;
  logic         rst;
  logic [511:0] in_block;
  logic [255:0] in_chain;
  logic         in_use_iv;
  logic         in_valid   [4];
  logic         in_ready   [4];
  logic         out_valid  [4];
  logic         out_ready  [4];
  logic         busy       [4];
  logic [255:0] out_digest [4];

  int checks   = 0;
  int failures = 0;

  sha256_block_engine #(.UNROLL(1), .OUT_REG(1'b1)) u_dut_u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_block(in_block),
    .in_chain(in_chain), .in_use_iv(in_use_iv), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_digest(out_digest[0]), .busy(busy[0]));
  sha256_block_engine #(.UNROLL(2), .OUT_REG(1'b0)) u_dut_u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_block(in_block),
    .in_chain(in_chain), .in_use_iv(in_use_iv), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_digest(out_digest[1]), .busy(busy[1]));
  sha256_block_engine #(.UNROLL(4), .OUT_REG(1'b1)) u_dut_u4 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_block(in_block),
    .in_chain(in_chain), .in_use_iv(in_use_iv), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .out_digest(out_digest[2]), .busy(busy[2]));
  sha256_block_engine #(.UNROLL(8), .OUT_REG(1'b1)) u_dut_u8 (
    .clk(clk), .rst(rst), .in_valid(in_valid[3]), .in_ready(in_ready[3]), .in_block(in_block),
    .in_chain(in_chain), .in_use_iv(in_use_iv), .out_valid(out_valid[3]), .out_ready(out_ready[3]),
    .out_digest(out_digest[3]), .busy(busy[3]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] rotr32(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Textbook SHA-256 compression: full 64-word schedule, then 64 rounds, then feed-forward.
  function automatic logic [255:0] ref_compress(input logic [255:0] chain, input logic [511:0] blk);
    logic [31:0]  w  [64];
    logic [31:0]  hv [8];
    logic [31:0]  wv [8];
    logic [31:0]  t1, t2, s0, s1;
    logic [255:0] res;
    for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0   = rotr32(w[i-15], 7) ^ rotr32(w[i-15], 18) ^ (w[i-15] >> 3);
      s1   = rotr32(w[i-2], 17) ^ rotr32(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    for (int i = 0; i < 8; i++) begin
      hv[i] = chain[255 - 32*i -: 32];
      wv[i] = hv[i];
    end
    for (int t = 0; t < 64; t++) begin
      s1 = rotr32(wv[4], 6) ^ rotr32(wv[4], 11) ^ rotr32(wv[4], 25);
      t1 = wv[7] + s1 + ((wv[4] & wv[5]) ^ (~wv[4] & wv[6])) + TB_K[t] + w[t];
      s0 = rotr32(wv[0], 2) ^ rotr32(wv[0], 13) ^ rotr32(wv[0], 22);
      t2 = s0 + ((wv[0] & wv[1]) ^ (wv[0] & wv[2]) ^ (wv[1] & wv[2]));
      for (int i = 7; i > 0; i--) wv[i] = wv[i-1];
      wv[4] = wv[4] + t1;
      wv[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) res[255 - 32*i -: 32] = hv[i] + wv[i];
    return res;
  endfunction

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // Present one block, then wait (bounded) for out_valid. lat counts clock edges
  // starting with the accept edge as 1; a timeout leaves lat at 300.
  task automatic run_block(input int k, input logic [255:0] chain, input logic use_iv,
                           input logic [511:0] blk, input bit scramble,
                           output logic [255:0] dig, output int lat);
    @(negedge clk);
    in_chain    = chain;
    in_use_iv   = use_iv;
    in_block    = blk;
    in_valid[k] = 1'b1;
    @(posedge clk);
    #1;
    in_valid[k] = 1'b0;
    lat = 1;
    while (out_valid[k] !== 1'b1 && lat < 300) begin
      if (scramble) begin
        in_block  = rand512();
        in_chain  = rand256();
        in_use_iv = 1'($urandom);
      end
      @(posedge clk);
      #1;
      lat++;
    end
    dig = out_digest[k];
  endtask

  task automatic drain(input int k);
    @(negedge clk);
    out_ready[k] = 1'b1;
    @(posedge clk);
    #1;
    out_ready[k] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      checks++; if (in_ready[k] !== 1'b1) begin failures++; $display("FAIL reset_in_ready[%0d]: got %b expected 1", k, in_ready[k]); end
      checks++; if (out_valid[k] !== 1'b0) begin failures++; $display("FAIL reset_out_valid[%0d]: got %b expected 0", k, out_valid[k]); end
      checks++; if (busy[k] !== 1'b0) begin failures++; $display("FAIL reset_busy[%0d]: got %b expected 0", k, busy[k]); end
      checks++; if (out_digest[k] !== 256'h0) begin failures++; $display("FAIL reset_digest[%0d]: got %h expected 0", k, out_digest[k]); end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_abc();
    logic [255:0] d;
    int lat;
    run_block(0, '0, 1'b1, ABC_BLK, 1'b0, d, lat);
    checks++; if (d !== ABC_DIG) begin failures++; $display("FAIL abc_digest: got %h expected %h", d, ABC_DIG); end
    checks++; if (d !== ref_compress(TB_IV, ABC_BLK)) begin failures++; $display("FAIL abc_model: got %h expected %h", d, ref_compress(TB_IV, ABC_BLK)); end
    checks++; if (lat != 65) begin failures++; $display("FAIL abc_latency: got %0d expected 65", lat); end
    checks++; if (in_ready[0] !== 1'b0 || busy[0] !== 1'b1) begin failures++; $display("FAIL abc_done_flags: got in_ready=%b busy=%b expected 0/1", in_ready[0], busy[0]); end
    drain(0);
  endtask

  task automatic test_empty();
    logic [255:0] d;
    int lat;
    run_block(2, '0, 1'b1, EMPTY_BLK, 1'b0, d, lat);
    checks++; if (d !== EMPTY_DIG) begin failures++; $display("FAIL empty_digest: got %h expected %h", d, EMPTY_DIG); end
    checks++; if (lat != 17) begin failures++; $display("FAIL empty_latency: got %0d expected 17", lat); end
    drain(2);
  endtask

  task automatic test_two_block();
    logic [255:0] d1, d2;
    int lat;
    int sel [3] = '{0, 1, 3};
    for (int n = 0; n < 3; n++) begin
      run_block(sel[n], '0, 1'b1, TWO_BLK1, 1'b0, d1, lat);
      checks++; if (d1 !== ref_compress(TB_IV, TWO_BLK1)) begin failures++; $display("FAIL two_blk1[u%0d]: got %h expected %h", UNROLL_OF[sel[n]], d1, ref_compress(TB_IV, TWO_BLK1)); end
      drain(sel[n]);
      run_block(sel[n], d1, 1'b0, TWO_BLK2, sel[n] == 3, d2, lat);
      checks++; if (d2 !== TWO_DIG) begin failures++; $display("FAIL two_final[u%0d]: got %h expected %h", UNROLL_OF[sel[n]], d2, TWO_DIG); end
      checks++; if (lat != 64 / UNROLL_OF[sel[n]] + 1) begin failures++; $display("FAIL two_latency[u%0d]: got %0d expected %0d", UNROLL_OF[sel[n]], lat, 64 / UNROLL_OF[sel[n]] + 1); end
      drain(sel[n]);
    end
  endtask

  task automatic test_backpressure();
    logic [255:0] d;
    int lat;
    run_block(0, '0, 1'b1, ABC_BLK, 1'b0, d, lat);
    checks++; if (d !== ABC_DIG) begin failures++; $display("FAIL bp_first_digest: got %h expected %h", d, ABC_DIG); end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      in_block    = rand512();
      in_chain    = rand256();
      in_use_iv   = 1'b0;
      in_valid[0] = 1'b1;
      @(posedge clk);
      #1;
      checks++; if (out_valid[0] !== 1'b1) begin failures++; $display("FAIL bp_out_valid[c%0d]: got %b expected 1", c, out_valid[0]); end
      checks++; if (in_ready[0] !== 1'b0) begin failures++; $display("FAIL bp_in_ready[c%0d]: got %b expected 0", c, in_ready[0]); end
      checks++; if (out_digest[0] !== ABC_DIG) begin failures++; $display("FAIL bp_stable[c%0d]: got %h expected %h", c, out_digest[0], ABC_DIG); end
    end
    @(negedge clk);
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    out_ready[0] = 1'b0;
    checks++; if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0 || busy[0] !== 1'b0) begin failures++; $display("FAIL bp_release: got in_ready=%b out_valid=%b busy=%b expected 1/0/0", in_ready[0], out_valid[0], busy[0]); end
    checks++; if (out_digest[0] !== ABC_DIG) begin failures++; $display("FAIL bp_held_digest: got %h expected %h", out_digest[0], ABC_DIG); end
    run_block(0, '0, 1'b1, ABC_BLK, 1'b0, d, lat);
    checks++; if (d !== ABC_DIG || lat != 65) begin failures++; $display("FAIL bp_next_block: got %h lat %0d expected %h lat 65", d, lat, ABC_DIG); end
    drain(0);
  endtask

  task automatic test_back_to_back();
    logic [511:0] blk_a, blk_b;
    logic [255:0] digs [$];
    int           acc  [$];
    bit           take;
    blk_a = rand512();
    blk_b = rand512();
    @(negedge clk);
    in_block     = blk_a;
    in_use_iv    = 1'b1;
    in_valid[3]  = 1'b1;
    out_ready[3] = 1'b1;
    for (int c = 0; c < 80 && digs.size() < 2; c++) begin
      take = in_valid[3] && in_ready[3];
      if (out_valid[3] === 1'b1) digs.push_back(out_digest[3]);
      if (take) acc.push_back(c);
      @(posedge clk);
      #1;
      if (take) begin
        if (acc.size() == 1) in_block = blk_b;
        else in_valid[3] = 1'b0;
      end
      @(negedge clk);
    end
    in_valid[3]  = 1'b0;
    out_ready[3] = 1'b0;
    checks++; if (acc.size() != 2 || digs.size() != 2) begin failures++; $display("FAIL b2b_counts: got accepts=%0d digests=%0d expected 2/2", acc.size(), digs.size()); end
    else begin
      checks++; if (acc[1] - acc[0] != 10) begin failures++; $display("FAIL b2b_period: got %0d expected 10", acc[1] - acc[0]); end
      checks++; if (digs[0] !== ref_compress(TB_IV, blk_a)) begin failures++; $display("FAIL b2b_digest_a: got %h expected %h", digs[0], ref_compress(TB_IV, blk_a)); end
      checks++; if (digs[1] !== ref_compress(TB_IV, blk_b)) begin failures++; $display("FAIL b2b_digest_b: got %h expected %h", digs[1], ref_compress(TB_IV, blk_b)); end
    end
  endtask

  task automatic test_reset_mid();
    logic [255:0] d;
    int lat;
    @(negedge clk);
    in_block    = ABC_BLK;
    in_use_iv   = 1'b1;
    in_valid[0] = 1'b1;
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    repeat (29) begin
      @(posedge clk);
      #1;
    end
    checks++; if (busy[0] !== 1'b1 || out_valid[0] !== 1'b0) begin failures++; $display("FAIL mid_running: got busy=%b out_valid=%b expected 1/0", busy[0], out_valid[0]); end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1 || busy[0] !== 1'b0) begin failures++; $display("FAIL mid_reset: got out_valid=%b in_ready=%b busy=%b expected 0/1/0", out_valid[0], in_ready[0], busy[0]); end
    @(negedge clk);
    rst = 1'b0;
    run_block(0, '0, 1'b1, ABC_BLK, 1'b0, d, lat);
    checks++; if (d !== ABC_DIG || lat != 65) begin failures++; $display("FAIL mid_after_reset: got %h lat %0d expected %h lat 65", d, lat, ABC_DIG); end
    drain(0);
  endtask

  task automatic test_sample_once();
    logic [511:0] blk;
    logic [255:0] chain, d, exp_d;
    logic         use_iv;
    int lat;
    run_block(2, rand256(), 1'b1, ABC_BLK, 1'b1, d, lat);
    checks++; if (d !== ABC_DIG) begin failures++; $display("FAIL once_abc: got %h expected %h", d, ABC_DIG); end
    drain(2);
    for (int k = 0; k < 4; k++) begin
      for (int n = 0; n < 2; n++) begin
        blk    = rand512();
        chain  = rand256();
        use_iv = 1'(n);
        exp_d  = ref_compress(use_iv ? TB_IV : chain, blk);
        run_block(k, chain, use_iv, blk, 1'b1, d, lat);
        checks++; if (d !== exp_d) begin failures++; $display("FAIL once_rand[u%0d,%0d]: got %h expected %h", UNROLL_OF[k], n, d, exp_d); end
        drain(k);
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_block  = '0;
    in_chain  = '0;
    in_use_iv = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid[k]  = 1'b0;
      out_ready[k] = 1'b0;
    end
    test_reset();
    test_abc();
    test_empty();
    test_two_block();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_sample_once();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sha256_block_engine.md
Name: sha256_block_engine

Overview:
Iterative SHA-256 compression engine for the mining datapath. It accepts one 512-bit message block plus a 256-bit chaining value, or selects the standard IV, and runs the 64 rounds at UNROLL rounds per clock. It returns the 256-bit updated digest through a valid/ready handshake. It replaces the fixed single-round hash stage and adds a message schedule, feed-forward addition, flow control and selectable throughput.

Parameters:
UNROLL, 1, rounds computed per clock; legal values 1, 2, 4, 8 (must divide 64); any other value is an elaboration-time error.
OUT_REG, 1, 1 = digest held in a dedicated output register; 0 = digest driven combinationally from state in DONE.

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
in_valid  in  1  block/chain presented
in_ready  out  1  engine can accept a block (high only in IDLE)
in_block  in  512  message block; word W0 = bits [511:480], big-endian words
in_chain  in  256  chaining value; H0 = bits [255:224]
in_use_iv  in  1  1 = ignore in_chain and use the SHA-256 IV
out_valid  out  1  digest available
out_ready  in  1  consumer accepts digest
out_digest  out  256  H0..H7 after feed-forward, H0 in MSBs
busy  out  1  state != IDLE

Behaviour:
- Clocking and reset: one clock, clk. rst is synchronous, active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, out_digest=0, round counter=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready, at that edge: latch W[0..15] from in_block into a 16-entry circular schedule buffer.
  - Latch H[0..7] from the IV, or from in_chain if in_use_iv=0. Load a..h from the same value.
  - Clear the round counter and go to RUN.
- RUN:
  - Each cycle, perform UNROLL chained rounds t..t+UNROLL-1 using K[t] and W[t].
  - For t>=16: W[t] = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16], mod 2^32. Computed in-buffer (W[t] overwrites slot t mod 16).
  - Counter advances by UNROLL. When the counter reaches 64, go to DONE.
  - RUN lasts exactly 64/UNROLL cycles.
- Entering DONE:
  - Digest word i = H[i] + working var i, mod 2^32, carries discarded.
  - out_valid=1 on the first DONE cycle. Latency from the accept edge to out_valid high is 64/UNROLL+1 clocks.
- DONE:
  - out_valid and out_digest are held stable until out_ready.
  - On out_valid && out_ready: go to IDLE, and out_valid=0 next cycle.
  - With OUT_REG=1, out_digest keeps its last value afterwards. With OUT_REG=0, it is undefined outside DONE.
- No overlap: a new block is never accepted in RUN or DONE. in_valid in those states is ignored and the producer must hold.
- Back-to-back: out_ready=1 in DONE gives IDLE next cycle. The earliest next accept is that IDLE cycle, so throughput is one block per 64/UNROLL+2 clocks.
- Held inputs: in_chain, in_block and in_use_iv are sampled only at the accept edge and may change afterwards.
- Reset mid-operation: rst in RUN or DONE aborts with no output. All outputs take reset values at the next edge, and a pending digest is lost.
- Simultaneous events: rst has priority over any handshake in the same cycle.

Decomposition:
- sha256_pkg holds:
  - K[0:63] constant table and the 8-word IV constant.
  - typedef word_t (32 bits) and typedef state_t (8 x word_t).
  - FSM enum.
  - Functions ch, maj, Sigma0, Sigma1, sigma0, sigma1.
- Sub-module sha256_round: purely combinational single round (a..h, W, K -> a'..h'). It is generated UNROLL times in a chain.
- The schedule expansion stays in the engine.

Test Plan:
- "abc" (one padded block, in_use_iv=1), UNROLL=1 -> out_digest = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad, with out_valid rising exactly 65 clocks after the accept edge.
- Empty string (block 80000000 followed by zeros), UNROLL=4 -> e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855, with latency 17 clocks.
- Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" -> final digest 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
  - Block 1 runs with in_use_iv=1.
  - Block 2 runs with in_use_iv=0 and in_chain = block-1 digest.
  - Run at UNROLL=1, 2 and 8.
- Backpressure: hold out_ready=0 for 20 cycles in DONE -> out_digest stable, in_ready=0, and a second in_valid is ignored. Raising out_ready gives IDLE the next cycle.
- Reset at RUN cycle 30 -> next cycle out_valid=0, in_ready=1, busy=0. The following "abc" block still produces the correct digest.
- Sample-once inputs: toggle in_block and in_chain randomly after acceptance -> the digest is unchanged from the expected "abc" value.
